// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Define DCACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module dcache_responder #(
  parameter int IDX_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int NUM_LINES = 2 ** IDX_W;
  // Tag covers proc_addr[29:IDX_W+2] so {tag, index} spans the full 28-bit block address.
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [127:0]         data_arr [NUM_LINES];

  logic [1:0]       offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [27:0]      blk_addr;
  logic [127:0]     line;
  logic             req;
  logic             hit;
  logic             idle_hit;
  logic             idle_miss;
  logic             victim_dirty;

  assign offset       = proc_addr[1:0];
  assign index        = proc_addr[IDX_W+1:2];
  assign tag          = proc_addr[29:IDX_W+2];
  assign blk_addr     = proc_addr[29:2];
  assign line         = data_arr[index];
  assign req          = proc_read | proc_write;
  assign hit          = valid[index] && (tag_arr[index] == tag);
  assign idle_hit     = (state == IDLE) && req && hit;
  assign idle_miss    = (state == IDLE) && req && !hit;
  assign victim_dirty = valid[index] && dirty[index];

  // Stall and read data are combinational so hits complete with no bubble.
  assign proc_stall = rst_n && ((state != IDLE) || idle_miss);
  assign proc_rdata = (idle_hit && proc_read) ? line[{offset, 5'b0} +: 32] : 32'd0;

`ifdef DCACHE_STATS_EN
  logic refilled;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
`ifdef DCACHE_STATS_EN
      hit_cnt   <= 32'd0;
      miss_cnt  <= 32'd0;
      refilled  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (idle_hit && proc_write) dirty[index] <= 1'b1;
          if (idle_miss) begin
            if (victim_dirty) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
            end else begin
              state     <= ALLOCATE;
              mem_read  <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            dirty[index] <= 1'b0;
            state        <= ALLOCATE;
            mem_write    <= 1'b0;
            mem_read     <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
            state        <= IDLE;
            mem_read     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef DCACHE_STATS_EN
      // A hit right after a refill finishes a miss and is not a first-presentation hit.
      if (idle_hit && !refilled) hit_cnt <= sat_inc(hit_cnt);
      if (idle_miss) miss_cnt <= sat_inc(miss_cnt);
      if (state == ALLOCATE && mem_ready) refilled <= 1'b1;
      else if (state == IDLE) refilled <= 1'b0;
`endif
    end
  end

  // Line storage and memory request payload carry no reset.
  always_ff @(posedge clk) begin
    if (idle_hit && proc_write) data_arr[index][{offset, 5'b0} +: 32] <= proc_wdata;
    if (state == ALLOCATE && mem_ready) begin
      data_arr[index] <= mem_rdata;
      tag_arr[index]  <= tag;
    end
    if (idle_miss) begin
      mem_addr  <= victim_dirty ? {tag_arr[index], index} : blk_addr;
      mem_wdata <= line;
    end else if (state == WRITEBACK && mem_ready) begin
      mem_addr  <= blk_addr;
    end
  end

endmodule
